// File: rtl/vc4000_pad_pkg.sv
// Shared types and helpers for the VC4000 pad integrator: mode encoding,
// joystick bit positions and the saturating pot adder.
package vc4000_pad_pkg;

  typedef enum logic [1:0] {
    ST_ABS      = 2'd0,
    ST_INT      = 2'd1,
    ST_RECENTER = 2'd2
  } mode_t;

  // Bit positions inside each player's 4-bit {up,down,left,right} nibble
  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  localparam int POT_MAX_W = 12;
  localparam int DELTA_W   = POT_MAX_W + 2;

  typedef logic [POT_MAX_W-1:0]      wide_pot_t;
  typedef logic signed [DELTA_W-1:0] delta_t;

  // pot + delta clamped to [0, 2^pot_w-1]; computed wide enough that no
  // intermediate value can wrap for any supported pot width.
  function automatic wide_pot_t sat_add(input wide_pot_t pot, input delta_t delta,
                                        input int pot_w);
    logic signed [DELTA_W:0] sum;
    logic signed [DELTA_W:0] lim;
    logic signed [DELTA_W:0] one;
    wide_pot_t res;
    one = 1;
    sum = $signed({2'b00, pot}) + $signed({delta[DELTA_W-1], delta});
    lim = (one <<< pot_w) - one;
    if (sum < 0)
      res = '0;
    else if (sum > lim)
      res = lim[POT_MAX_W-1:0];
    else
      res = sum[POT_MAX_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/vc4000_pad_axis.sv
// One pot axis: holds the pot register and applies absolute, integrating
// or recentering updates as selected by the global mode.
module vc4000_pad_axis
  import vc4000_pad_pkg::*;
#(
  parameter int POT_W = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             tick,
  input  logic             minus,
  input  logic             plus,
  input  logic [7:0]       ana,
  output logic [POT_W-1:0] pot,
  output logic             changed
);

  localparam logic [POT_W-1:0] CENTER = {1'b1, {(POT_W-1){1'b0}}};
  localparam logic [POT_W-1:0] MAXV   = '1;

  mode_t            m;
  delta_t           d_ana;
  delta_t           d_step;
  logic [POT_W-1:0] nxt;

  assign m      = mode_t'(mode);
  // Analog is signed 8-bit; scale it up so full deflection spans the pot
  assign d_ana  = delta_t'($signed(ana)) <<< (POT_W - 8);
  assign d_step = delta_t'(STEP);

  always_comb begin
    nxt = pot;
    case (m)
      ST_RECENTER: nxt = CENTER;
      ST_ABS: begin
        if (ana != 8'd0)
          nxt = POT_W'(sat_add(wide_pot_t'(CENTER), d_ana, POT_W));
        else if (minus && !plus)
          nxt = '0;
        else if (plus && !minus)
          nxt = MAXV;
        else
          nxt = CENTER;
      end
      ST_INT: begin
        if (tick) begin
          if (minus && !plus)
            nxt = POT_W'(sat_add(wide_pot_t'(pot), -d_step, POT_W));
          else if (plus && !minus)
            nxt = POT_W'(sat_add(wide_pot_t'(pot), d_step, POT_W));
        end
      end
      default: nxt = pot;
    endcase
  end

  assign changed = (nxt != pot);

  always_ff @(posedge clk) begin
    if (reset)
      pot <= CENTER;
    else
      pot <= nxt;
  end

endmodule

// File: rtl/vc4000_pad_integrator.sv
// Maps MiSTer joystick/analog inputs onto per-player VC4000 X/Y pots, with
// absolute and integrating modes plus player and axis swapping.
module vc4000_pad_integrator
  import vc4000_pad_pkg::*;
#(
  parameter int NPLAYERS = 2,
  parameter int POT_W    = 8,
  parameter int RATE_DIV = 16384,
  parameter int STEP     = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NPLAYERS-1:0]     joy_dig,
  input  logic [16*NPLAYERS-1:0]    joy_ana,
  input  logic                      integ,
  input  logic                      swap,
  input  logic                      swapxy,
  output logic [POT_W*NPLAYERS-1:0] pot_x,
  output logic [POT_W*NPLAYERS-1:0] pot_y,
  output logic                      pot_upd
);

  localparam int PS_W = $clog2(RATE_DIV);

  logic [PS_W-1:0]       presc;
  logic                  integ_q;
  logic                  tick;
  mode_t                 mode;
  logic [2*NPLAYERS-1:0] changed;

  assign tick = (presc == PS_W'(RATE_DIV - 1));

  // A mode change always costs one recenter cycle, even on a tick
  always_comb begin
    if (integ != integ_q)
      mode = ST_RECENTER;
    else if (integ_q)
      mode = ST_INT;
    else
      mode = ST_ABS;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      integ_q <= 1'b0;
      pot_upd <= 1'b0;
    end else begin
      integ_q <= integ;
      pot_upd <= |changed;
      if (mode == ST_RECENTER || tick)
        presc <= '0;
      else
        presc <= presc + 1'b1;
    end
  end

  for (genvar p = 0; p < NPLAYERS; p++) begin : g_pl
    localparam int SRC = NPLAYERS - 1 - p;

    logic [3:0] dig;
    logic [7:0] ax;
    logic [7:0] ay;
    logic       x_minus, x_plus, y_minus, y_plus;
    logic [7:0] x_ana, y_ana;

    assign dig = swap ? joy_dig[4*SRC +: 4]      : joy_dig[4*p +: 4];
    assign ax  = swap ? joy_ana[16*SRC +: 8]     : joy_ana[16*p +: 8];
    assign ay  = swap ? joy_ana[16*SRC + 8 +: 8] : joy_ana[16*p + 8 +: 8];

    assign x_minus = swapxy ? dig[DIR_UP]   : dig[DIR_LEFT];
    assign x_plus  = swapxy ? dig[DIR_DOWN] : dig[DIR_RIGHT];
    assign x_ana   = swapxy ? ay : ax;
    assign y_minus = swapxy ? dig[DIR_LEFT]  : dig[DIR_UP];
    assign y_plus  = swapxy ? dig[DIR_RIGHT] : dig[DIR_DOWN];
    assign y_ana   = swapxy ? ax : ay;

    vc4000_pad_axis #(.POT_W(POT_W), .STEP(STEP)) u_x (
      .clk     (clk),
      .reset   (reset),
      .mode    (mode),
      .tick    (tick),
      .minus   (x_minus),
      .plus    (x_plus),
      .ana     (x_ana),
      .pot     (pot_x[POT_W*p +: POT_W]),
      .changed (changed[2*p])
    );

    vc4000_pad_axis #(.POT_W(POT_W), .STEP(STEP)) u_y (
      .clk     (clk),
      .reset   (reset),
      .mode    (mode),
      .tick    (tick),
      .minus   (y_minus),
      .plus    (y_plus),
      .ana     (y_ana),
      .pot     (pot_y[POT_W*p +: POT_W]),
      .changed (changed[2*p + 1])
    );
  end

endmodule

// File: tb/tb_vc4000_pad_integrator.sv
// Scoreboard bench for vc4000_pad_integrator: directed scenarios followed by
// random traffic, checked against an integer-arithmetic reference model.
module tb_vc4000_pad_integrator;

  localparam int NP   = 2;
  localparam int PW   = 8;
  localparam int RD   = 4;
  localparam int STP  = 1;
  localparam int MAXV = (1 << PW) - 1;
  localparam int CEN  = 1 << (PW - 1);

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                integ = 1'b0;
  logic                swap = 1'b0;
  logic                swapxy = 1'b0;
  logic [4*NP-1:0]     joy_dig = '0;
  logic [16*NP-1:0]    joy_ana = '0;
  logic [PW*NP-1:0]    pot_x;
  logic [PW*NP-1:0]    pot_y;
  logic                pot_upd;

  always #5 clk = ~clk;

  vc4000_pad_integrator #(.NPLAYERS(NP), .POT_W(PW), .RATE_DIV(RD), .STEP(STP)) dut (
    .clk     (clk),
    .reset   (reset),
    .joy_dig (joy_dig),
    .joy_ana (joy_ana),
    .integ   (integ),
    .swap    (swap),
    .swapxy  (swapxy),
    .pot_x   (pot_x),
    .pot_y   (pot_y),
    .pot_upd (pot_upd)
  );

  typedef struct packed {
    logic [PW*NP-1:0] px;
    logic [PW*NP-1:0] py;
    logic             upd;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state
  int m_x[NP];
  int m_y[NP];
  int m_cyc;   // cycles since last prescaler restart
  bit m_iq;

  function automatic int clampv(int v);
    if (v < 0) return 0;
    if (v > MAXV) return MAXV;
    return v;
  endfunction

  function automatic int axis_next(int cur, bit minus, bit plus, int a, bit int_mode, bit tk);
    if (!int_mode) begin
      if (a != 0) return clampv(CEN + a * (1 << (PW - 8)));
      if (minus && !plus) return 0;
      if (plus && !minus) return MAXV;
      return CEN;
    end
    if (!tk) return cur;
    if (minus && !plus) return clampv(cur - STP);
    if (plus && !minus) return clampv(cur + STP);
    return cur;
  endfunction

  task automatic drive(bit r, bit ig, bit sw, bit sxy,
                       logic [4*NP-1:0] dg, logic [16*NP-1:0] an);
    exp_t             e;
    bit               upd;
    bit               tk;
    int               nx[NP];
    int               ny[NP];
    int               q;
    logic [3:0]       d;
    logic signed [7:0] sx;
    logic signed [7:0] sy;
    @(negedge clk);
    reset = r; integ = ig; swap = sw; swapxy = sxy; joy_dig = dg; joy_ana = an;
    upd = 1'b0;
    if (r) begin
      for (int p = 0; p < NP; p++) begin nx[p] = CEN; ny[p] = CEN; end
      m_cyc = 0;
      m_iq = 1'b0;
    end else if (ig != m_iq) begin
      for (int p = 0; p < NP; p++) begin nx[p] = CEN; ny[p] = CEN; end
      m_cyc = 0;
      m_iq = ig;
    end else begin
      tk = (m_cyc == RD - 1);
      m_cyc = tk ? 0 : m_cyc + 1;
      for (int p = 0; p < NP; p++) begin
        q  = sw ? NP - 1 - p : p;
        d  = dg[4*q +: 4];
        sx = an[16*q +: 8];
        sy = an[16*q + 8 +: 8];
        if (!sxy) begin
          nx[p] = axis_next(m_x[p], d[1], d[0], int'(sx), m_iq, tk);
          ny[p] = axis_next(m_y[p], d[3], d[2], int'(sy), m_iq, tk);
        end else begin
          nx[p] = axis_next(m_x[p], d[3], d[2], int'(sy), m_iq, tk);
          ny[p] = axis_next(m_y[p], d[1], d[0], int'(sx), m_iq, tk);
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (!r && (nx[p] != m_x[p] || ny[p] != m_y[p])) upd = 1'b1;
      m_x[p] = nx[p];
      m_y[p] = ny[p];
      e.px[PW*p +: PW] = PW'(m_x[p]);
      e.py[PW*p +: PW] = PW'(m_y[p]);
    end
    e.upd = upd;
    sb.push_back(e);
  endtask

  // Monitor: outputs are registered, so each vector is visible after the next edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (pot_x !== e.px || pot_y !== e.py || pot_upd !== e.upd) begin
          miscompares++;
          if (miscompares <= 20)
            $display("FAIL pots vec %0d: got x=%h y=%h upd=%b, want x=%h y=%h upd=%b",
                     vectors, pot_x, pot_y, pot_upd, e.px, e.py, e.upd);
        end
      end
    end
  end

  initial begin
    logic [4*NP-1:0]  dg;
    logic [16*NP-1:0] an;
    bit ig, sw, sxy, r;
    int n;

    for (int p = 0; p < NP; p++) begin m_x[p] = CEN; m_y[p] = CEN; end
    m_cyc = 0;
    m_iq = 1'b0;

    repeat (3) drive(1, 0, 0, 0, '0, '0);

    // Absolute mode: digital extremes, both pressed, analog scaling
    drive(0, 0, 0, 0, 8'h01, '0);
    drive(0, 0, 0, 0, 8'h03, '0);
    drive(0, 0, 0, 0, '0, 32'h0000_0040);
    drive(0, 0, 0, 0, '0, 32'h0000_0080);
    drive(0, 0, 0, 0, 8'h01, 32'h0000_0020);
    drive(0, 0, 0, 0, '0, '0);

    // Player and axis swapping
    drive(0, 0, 1, 0, 8'h02, '0);
    drive(0, 0, 1, 1, 8'h02, '0);
    drive(0, 0, 1, 1, 8'h02, '0);

    // Integration mode: hold P1 down through saturation
    drive(0, 1, 0, 0, '0, '0);
    repeat (12) drive(0, 1, 0, 0, 8'h40, 32'h7f7f_7f7f);
    repeat (530) drive(0, 1, 0, 0, 8'h40, '0);

    // Walk P0 X to 0x90, then leave integration exactly on a tick
    n = 0;
    while (m_x[0] != 'h90 && n < 200) begin
      drive(0, 1, 0, 0, 8'h01, '0);
      n++;
    end
    n = 0;
    while (m_cyc != RD - 1 && n < 2 * RD) begin
      drive(0, 1, 0, 0, '0, '0);
      n++;
    end
    drive(0, 0, 0, 0, '0, '0);
    drive(0, 0, 0, 0, '0, '0);

    // Random traffic
    ig = 1'b0; sw = 1'b0; sxy = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(99) == 0);
      if ($urandom_range(49) == 0) ig = ~ig;
      if ($urandom_range(49) == 0) sw = ~sw;
      if ($urandom_range(49) == 0) sxy = ~sxy;
      dg = (4*NP)'($urandom);
      for (int b = 0; b < 2 * NP; b++)
        an[8*b +: 8] = ($urandom_range(1) == 1) ? 8'($urandom) : 8'h00;
      drive(r, ig, sw, sxy, dg, an);
    end

    n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vc4000_pad_integrator.md
Name: vc4000_pad_integrator

Overview:
- Converts MiSTer digital joystick and analog-stick inputs into the per-player X/Y potentiometer values read by the VC4000 core.
- Generalised to N players and a configurable pot width.
- Two modes: absolute (stick or d-pad maps directly to a position) and integration (d-pad moves the pot at a fixed rate and holds it).
- Sits between hps_io and vc4000_core; also owns the player-swap and XY-swap options.

Parameters:
NPLAYERS, 2, number of player channels (1..4)
POT_W, 8, pot value width in bits (8..12)
RATE_DIV, 16384, clk cycles per integration tick (>=2)
STEP, 1, pot increment per tick in integration mode (1 .. 2^(POT_W-1)-1)

Ports:
clk  in  1  system clock (clksys)
reset  in  1  synchronous, active-high reset
joy_dig  in  4*NPLAYERS  per player {up,down,left,right} = bits [3:0] of joystick_N, player p at [4p+3:4p]
joy_ana  in  16*NPLAYERS  per player signed X in [7:0], signed Y in [15:8]
integ  in  1  0 = absolute mode, 1 = integration mode
swap  in  1  player p is driven by input NPLAYERS-1-p
swapxy  in  1  X is driven by up/down and analog Y; Y is driven by left/right and analog X
pot_x  out  POT_W*NPLAYERS  X pot for player p at [POT_W*p +: POT_W]
pot_y  out  POT_W*NPLAYERS  Y pot for player p, same packing
pot_upd  out  1  one-cycle pulse in the cycle after any pot register changed

Behaviour:
- Constants: MAX = 2^POT_W-1; CENTER = 2^(POT_W-1).
- Reset: all pots = CENTER; pot_upd = 0; prescaler = 0; integ_q = 0.
- Prescaler: counts 0..RATE_DIV-1 and wraps. tick = 1 in the cycle the count equals RATE_DIV-1.
- Mode FSM (global):
  - States: ABS, INT, RECENTER.
  - RECENTER is entered whenever integ differs from integ_q. It lasts one cycle: all pots = CENTER, prescaler = 0.
  - Next state is ABS if integ=0, else INT. integ_q is updated in the same cycle.
- Axis mapping, per player after swap and swapxy:
  - minus = left (X) or up (Y).
  - plus = right (X) or down (Y).
  - a = analog X or analog Y respectively.
- ABS, every cycle (latency 1 from input to pot):
  - If a != 0: pot = CENTER + (sign-extend(a) << (POT_W-8)), clamped to [0, MAX]. Analog takes priority over digital.
  - Else minus only -> 0; plus only -> MAX; none or both -> CENTER.
- INT, only on tick:
  - minus only -> pot = max(pot-STEP, 0).
  - plus only -> pot = min(pot+STEP, MAX).
  - none or both -> hold.
  - joy_ana is ignored.
  - Arithmetic is done in POT_W+1 bits before saturating.
  - Between ticks the pots hold.
- Simultaneous events:
  - Mode change on a tick cycle: RECENTER wins and the tick is dropped.
  - swap/swapxy changes take effect on the next evaluation with no recentering.
- pot_upd: registered OR of (next != current) over all pot registers.
  - It is also 1 after RECENTER if any pot was not already CENTER.
  - It is 0 during reset.
- Reset mid-operation overrides everything in the same cycle.

Decomposition:
- Package vc4000_pad_pkg: state enum (ST_ABS, ST_INT, ST_RECENTER), the direction bit index localparams, and the function sat_add(pot, delta, POT_W).
- Sub-module vc4000_pad_axis: one instance per axis per player (2*NPLAYERS instances) holding the pot register and the ABS/INT update logic.
- The top level holds the prescaler, the FSM, the swap muxing and the pot_upd reduction.

Test Plan:
- Reset with NPLAYERS=2, POT_W=8 -> all four pots = 0x80, pot_upd = 0.
- ABS mode, P0 right -> pot_x[7:0] = 0xFF one cycle later. Left+right -> 0x80. Analog X = 0x40 -> 0xC0. Analog X = 0x80 (-128) -> 0x00.
- INT mode, RATE_DIV=4, STEP=1, P1 down held for 12 cycles -> pot_y[15:8] goes 0x80→0x81→0x82→0x83, one step per 4 cycles. Holding down from 0xFE -> saturates at 0xFF and pot_upd stops pulsing.
- swap=1, joy_dig player 0 = left -> player 1 pot_x = 0x00 and player 0 stays at 0x80. Adding swapxy=1 -> player 1 pot_y = 0x00 instead.
- INT mode with pot_x = 0x90, toggle integ to 0 in the cycle tick fires -> one RECENTER cycle, all pots = 0x80, pot_upd pulses, no step applied.
- POT_W=10, ABS mode, analog X = 0x7F -> pot = 512 + 508 = 1020.
